sram_stream_client: RTL and testbench

- Initiator-side partner of the SRAM controller. Sits at the boundary PE of the Smith-Waterman systolic array.
- Each pass, it fetches the previous pass's boundary column from SRAM by issuing one-word read requests. Fetched words are prefetched into a small FIFO for the first PE.
- In the same pass, it forwards the last PE's output words to SRAM as write sends.
- Tracks per-pass word counts, so the top level only starts and observes passes.

---
 rtl/sram_stream_client_pkg.sv | 15 +
 rtl/sw_prefetch_fifo.sv | 59 +++++
 rtl/sram_stream_client.sv | 136 +++++++++++++
 tb/tb_sram_stream_client.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_stream_client_pkg.sv
// Shared SRAM/pass constants and pass FSM encoding for the Smith-Waterman
// boundary stream client.
package sram_stream_client_pkg;

    localparam int SRAM_WORD_BIT = 8;
    localparam int SRAM_ADDR_BIT = 16;
    localparam int PASS_LEN_BIT  = 11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } pass_state_t;

endpackage

// File: rtl/sw_prefetch_fifo.sv
// Small synchronous FIFO with occupancy count; head word is visible
// combinationally. Write-through-on-empty is deliberately not provided.
module sw_prefetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_rd;
    logic             do_wr;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_rd   = rd_en && !empty;
    // A write while full is accepted only when the head leaves in the same cycle.
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_wr && !do_rd) begin
                count <= count + CW'(1);
            end else if (do_rd && !do_wr) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/sram_stream_client.sv
// Boundary-PE SRAM client: prefetches the previous pass's column through
// credit-limited read requests and forwards last-PE words as write sends.
module sram_stream_client
    import sram_stream_client_pkg::*;
#(
    parameter int WORD_BIT = SRAM_WORD_BIT,
    parameter int LEN_BIT  = PASS_LEN_BIT,
    parameter int PF_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_pass_start,
    input  logic [LEN_BIT-1:0]  i_len,
    input  logic                i_first_pass,
    output logic                o_req,
    input  logic [WORD_BIT-1:0] i_req_data,
    input  logic                i_req_valid,
    output logic                o_send,
    output logic [WORD_BIT-1:0] o_send_data,
    input  logic                i_pop,
    output logic [WORD_BIT-1:0] o_data,
    output logic                o_data_valid,
    input  logic                i_push,
    input  logic [WORD_BIT-1:0] i_push_data,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err
);

    localparam int CW = $clog2(PF_DEPTH) + 1;

    pass_state_t         state;
    logic [LEN_BIT-1:0]  len_r;
    logic [LEN_BIT-1:0]  rd_cnt;
    logic [LEN_BIT-1:0]  wr_cnt;
    logic [LEN_BIT-1:0]  issued;
    logic                first_r;
    logic [CW-1:0]       outstanding;
    logic [CW-1:0]       fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic [WORD_BIT-1:0] fifo_head;
    logic [CW:0]         credit_used;
    logic                fifo_wr;
    logic                pop_ok;
    logic                push_ok;
    logic                req_go;

    // Returned words with nothing outstanding are protocol errors and are dropped.
    assign fifo_wr      = i_req_valid && (outstanding != '0) && (!fifo_full || pop_ok);
    assign o_data_valid = first_r ? ((state == ST_RUN) && (rd_cnt != len_r)) : !fifo_empty;
    assign o_data       = (o_data_valid && !first_r) ? fifo_head : '0;
    assign pop_ok       = i_pop && o_data_valid;
    assign push_ok      = i_push && (state == ST_RUN) && (wr_cnt != len_r);
    // Words in flight count against FIFO space so returns can never overflow it.
    assign credit_used  = {1'b0, fifo_count} + {1'b0, outstanding};
    assign req_go       = (state == ST_RUN) && !first_r && (issued != len_r) &&
                          (credit_used < (CW+1)'(PF_DEPTH));

    sw_prefetch_fifo #(
        .WIDTH (WORD_BIT),
        .DEPTH (PF_DEPTH)
    ) u_prefetch (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data (i_req_data),
        .rd_en   (pop_ok && !first_r),
        .rd_data (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            len_r       <= '0;
            rd_cnt      <= '0;
            wr_cnt      <= '0;
            issued      <= '0;
            first_r     <= 1'b0;
            outstanding <= '0;
            o_req       <= 1'b0;
            o_send      <= 1'b0;
            o_send_data <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_req       <= req_go;
            outstanding <= outstanding + CW'(req_go) - CW'(fifo_wr);
            if (req_go) begin
                issued <= issued + LEN_BIT'(1);
            end
            if (pop_ok) begin
                rd_cnt <= rd_cnt + LEN_BIT'(1);
            end
            o_send <= push_ok;
            if (push_ok) begin
                o_send_data <= i_push_data;
                wr_cnt      <= wr_cnt + LEN_BIT'(1);
            end
            if ((i_req_valid && outstanding == '0) || (i_pop && !o_data_valid) ||
                (i_push && !push_ok) || (i_pass_start && state != ST_IDLE)) begin
                o_err <= 1'b1;
            end
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_pass_start) begin
                        state   <= ST_RUN;
                        o_busy  <= 1'b1;
                        len_r   <= (i_len == '0) ? LEN_BIT'(1) : i_len;
                        first_r <= i_first_pass;
                        rd_cnt  <= '0;
                        wr_cnt  <= '0;
                        issued  <= '0;
                    end
                end
                ST_RUN: begin
                    if (rd_cnt == len_r && wr_cnt == len_r && outstanding == '0) begin
                        state  <= ST_FINISH;
                        o_done <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_stream_client.sv
// Randomized bench for sram_stream_client: an in-order SRAM controller model
// and a word scoreboard check fetch order, credit limit, sends and pass control.
module tb_sram_stream_client;

    logic        clk;
    logic        rst;
    logic        i_pass_start;
    logic [10:0] i_len;
    logic        i_first_pass;
    logic        o_req;
    logic [7:0]  i_req_data;
    logic        i_req_valid;
    logic        o_send;
    logic [7:0]  o_send_data;
    logic        i_pop;
    logic [7:0]  o_data;
    logic        o_data_valid;
    logic        i_push;
    logic [7:0]  i_push_data;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    int n_cmp = 0;
    int n_bad = 0;

    sram_stream_client #(
        .WORD_BIT (8),
        .LEN_BIT  (11),
        .PF_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_pass_start (i_pass_start),
        .i_len        (i_len),
        .i_first_pass (i_first_pass),
        .o_req        (o_req),
        .i_req_data   (i_req_data),
        .i_req_valid  (i_req_valid),
        .o_send       (o_send),
        .o_send_data  (o_send_data),
        .i_pop        (i_pop),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .i_push       (i_push),
        .i_push_data  (i_push_data),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_pass_start = 1'b0;
        i_pop        = 1'b0;
        i_push       = 1'b0;
        i_push_data  = '0;
        i_req_valid  = 1'b0;
        i_req_data   = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({o_req, o_send, o_send_data, o_data, o_data_valid, o_busy, o_done, o_err});
    endfunction

    // One pass against the behavioural model. Words are expected in the order
    // the controller returned them (zeros on a first pass); a send must follow
    // each accepted push one cycle later with the same data.
    task automatic run_pass(input bit first, input int len_in, input int lat, input int hold,
                            input bit fixed, input bit rand_pop, input int restart_at,
                            input int bad_pop_at, input int abort_pops, input bit exp_err);
        int len_e;
        int cyc;
        int req_cnt;
        int pop_cnt;
        int push_cnt;
        int done_cnt;
        int max_fly;
        int word_idx;
        int late_done;
        int due_q[$];
        logic [7:0] exp_q[$];
        bit prev_push;
        logic [7:0] prev_data;

        len_e = (len_in == 0) ? 1 : len_in;
        cyc = 0; req_cnt = 0; pop_cnt = 0; push_cnt = 0; done_cnt = 0;
        max_fly = 0; word_idx = 0; late_done = 0;
        prev_push = 1'b0; prev_data = '0;
        if (first) repeat (len_e) exp_q.push_back(8'h00);

        clear_inputs();
        i_len = 11'(len_in);
        i_first_pass = first;
        i_pass_start = 1'b1;
        tick();
        check("busy_rise", 32'(o_busy), 1);

        while (done_cnt == 0 && cyc < 400) begin
            cyc++;
            clear_inputs();
            check("send_strobe", 32'(o_send), 32'(prev_push));
            if (prev_push) check("send_data", 32'(o_send_data), 32'(prev_data));
            if (o_done) done_cnt++;

            if (o_data_valid && cyc > hold && (!rand_pop || $urandom_range(0, 2) != 0)) begin
                i_pop = 1'b1;
                if (exp_q.size() == 0) check("pop_extra", 32'(o_data_valid), 0);
                else check("pop_data", 32'(o_data), 32'(exp_q.pop_front()));
                pop_cnt++;
            end else if (cyc == bad_pop_at) begin
                i_pop = 1'b1;
            end

            if (due_q.size() != 0 && due_q[0] == cyc) begin
                void'(due_q.pop_front());
                i_req_valid = 1'b1;
                i_req_data  = fixed ? 8'hA0 + 8'(word_idx) : 8'($urandom);
                word_idx++;
                exp_q.push_back(i_req_data);
            end
            if (o_req) begin
                req_cnt++;
                due_q.push_back(cyc + lat);
            end
            if (req_cnt - pop_cnt > max_fly) max_fly = req_cnt - pop_cnt;
            if (hold > 0 && cyc == hold)
                check("hold_reqs", 32'(req_cnt), first ? 0 : ((len_e < 4) ? len_e : 4));

            prev_push = 1'b0;
            if (push_cnt < len_e && $urandom_range(0, 1) == 1) begin
                i_push      = 1'b1;
                i_push_data = fixed ? 8'(8'h11 * (push_cnt + 1)) : 8'($urandom);
                prev_push   = 1'b1;
                prev_data   = i_push_data;
                push_cnt++;
            end
            if (cyc == restart_at) begin
                i_pass_start = 1'b1;
                i_len = 11'd1;
            end
            if (abort_pops != 0 && pop_cnt == abort_pops) break;
            tick();
        end

        if (abort_pops != 0) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            clear_inputs();
            check("rst_outs_zero", all_outs(), 0);
            repeat (10) begin
                tick();
                if (o_done || o_busy) late_done++;
            end
            check("no_done_after_rst", 32'(late_done), 0);
            return;
        end

        clear_inputs();
        check("done_seen", 32'(done_cnt), 1);
        check("busy_fall", 32'(o_busy), 0);
        check("done_pulse", 32'(o_done), 0);
        check("req_total", 32'(req_cnt), first ? 0 : len_e);
        check("pop_total", 32'(pop_cnt), len_e);
        check("inflight_max", 32'(max_fly <= 4), 1);
        check("err_flag", 32'(o_err), 32'(exp_err));
    endtask

    initial begin
        rst = 1'b1;
        i_len = '0;
        i_first_pass = 1'b0;
        clear_inputs();
        tick();
        tick();
        check("reset_outs", all_outs(), 0);
        rst = 1'b0;
        tick();

        // first pass: zeros, no reads, fixed 0x11/0x22/0x33 sends
        run_pass(1'b1, 3, 1, 0, 1'b1, 1'b0, 0, 0, 0, 1'b0);
        // normal pass, latency 1, data A0..A5
        run_pass(1'b0, 6, 1, 0, 1'b1, 1'b0, 0, 0, 0, 1'b0);
        // latency 5 with consumer stalled: credit limit stops issue at 4
        run_pass(1'b0, 6, 5, 20, 1'b1, 1'b0, 0, 0, 0, 1'b0);
        // zero length behaves as one word
        run_pass(1'b1, 0, 1, 0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        run_pass(1'b0, 0, 2, 0, 1'b0, 1'b0, 0, 0, 0, 1'b0);

        // unsolicited return in IDLE: error, word dropped, error sticky
        do_reset();
        i_req_valid = 1'b1;
        i_req_data  = 8'h5A;
        tick();
        clear_inputs();
        check("err_unsolicited", 32'(o_err), 1);
        check("unsolicited_dropped", 32'(o_data_valid), 0);
        tick();
        check("err_sticky", 32'(o_err), 1);
        do_reset();
        check("err_cleared", 32'(o_err), 0);

        // push while idle: error and no send
        i_push = 1'b1;
        i_push_data = 8'h77;
        tick();
        clear_inputs();
        check("idle_push_nosend", 32'(o_send), 0);
        check("err_idle_push", 32'(o_err), 1);

        // underflow pop at the first RUN cycle; pass must still complete
        do_reset();
        run_pass(1'b0, 4, 2, 0, 1'b0, 1'b0, 0, 1, 0, 1'b1);
        // second start during RUN is ignored (length not re-latched)
        do_reset();
        run_pass(1'b0, 4, 3, 0, 1'b0, 1'b0, 3, 0, 0, 1'b1);

        // reset after 2 of 5 words, then a clean len=2 pass
        do_reset();
        run_pass(1'b0, 5, 1, 0, 1'b0, 1'b0, 0, 0, 2, 1'b0);
        run_pass(1'b0, 2, 1, 0, 1'b0, 1'b0, 0, 0, 0, 1'b0);

        // randomized passes
        do_reset();
        for (int p = 0; p < 10; p++) begin
            run_pass(1'($urandom_range(0, 3) == 0), int'($urandom_range(1, 12)),
                     int'($urandom_range(1, 6)), 0, 1'b0, 1'b1, 0, 0, 0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
